// File: rtl/if_prefetch.sv
// Instruction-fetch stage: PC generation, 1-cycle synchronous RAM read issue, and a
// DEPTH-entry prefetch FIFO presented to ID over valid/ready, with branch flush.
module if_prefetch #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned     DEPTH     = 4,
   parameter int unsigned     MEM_AW    = 10,
   parameter bit              WORD_ADDR = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              br_en,
   input  logic [XLEN-1:0]   br_addr,
   output logic              imem_cs,
   output logic [MEM_AW-1:0] imem_addr,
   input  logic [XLEN-1:0]   imem_rdata,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [XLEN-1:0]   if_pc,
   output logic [XLEN-1:0]   if_inst
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] tag_q;
   logic            inflight_q;
   logic [PW-1:0]   rptr_q;
   logic [PW-1:0]   wptr_q;
   logic [PW:0]     count_q;
   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [XLEN-1:0] inst_mem_q [DEPTH];

   logic [XLEN-1:0] target;
   logic [XLEN-1:0] fetch_pc;
   logic [PW+1:0]   occupancy;
   logic            space;
   logic            push;
   logic            pop;

   always_comb begin
      target    = {br_addr[XLEN-1:2], 2'b00};
      fetch_pc  = br_en ? target : pc_q;
      // Reserve a slot for the in-flight read so a push can never hit a full FIFO.
      occupancy = {1'b0, count_q} + (PW+2)'(inflight_q);
      space     = occupancy < (PW+2)'(DEPTH);
      // Gated by rst_n so the RAM is idle the moment reset asserts.
      imem_cs   = rst_n & (br_en | space);
      if (WORD_ADDR) imem_addr = fetch_pc[MEM_AW+1:2];
      else           imem_addr = fetch_pc[MEM_AW-1:0];
      push      = inflight_q & ~br_en;
      if_valid  = (count_q != '0);
      pop       = if_valid & if_ready;
      if_pc     = if_valid ? pc_mem_q[rptr_q]   : '0;
      if_inst   = if_valid ? inst_mem_q[rptr_q] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
      end else begin
         if (imem_cs) begin
            pc_q  <= fetch_pc + XLEN'(4);
            tag_q <= fetch_pc;
         end
         inflight_q <= imem_cs;
         // A pop in the redirect cycle still completes; everything behind it is dropped.
         if (br_en) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
         end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
         end
      end
   end

   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wptr_q]   <= tag_q;
         inst_mem_q[wptr_q] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: streaming, back-pressure, redirects, PC wrap and async reset.
module tb_if_prefetch;

   logic        clk;
   logic        rst_n;
   logic        br_en;
   logic [31:0] br_addr;
   logic        if_ready;

   logic        imem_cs,  cs5;
   logic [9:0]  imem_addr, addr5;
   logic [31:0] imem_rdata, rdata5;
   logic        if_valid, valid5;
   logic [31:0] if_pc, pc5;
   logic [31:0] if_inst, inst5;

   int checks;
   int failures;

   if_prefetch #(
      .XLEN(32), .RESET_PC(32'h0), .DEPTH(4), .MEM_AW(10), .WORD_ADDR(1'b1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .br_en(br_en), .br_addr(br_addr),
      .imem_cs(imem_cs), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
   );

   if_prefetch #(
      .XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4), .MEM_AW(10), .WORD_ADDR(1'b0)
   ) u_dut5 (
      .clk(clk), .rst_n(rst_n), .br_en(1'b0), .br_addr(32'h0),
      .imem_cs(cs5), .imem_addr(addr5), .imem_rdata(rdata5),
      .if_valid(valid5), .if_ready(1'b1), .if_pc(pc5), .if_inst(inst5)
   );

   // RAM[i] = 0x1000_0000 + i, one-cycle read latency
   always @(posedge clk) begin
      if (imem_cs) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);
      if (cs5)     rdata5     <= 32'h1000_0000 + 32'(addr5);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      br_en    = 1'b0;
      br_addr  = 32'h0;
      if_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(if_valid), 32'd0);
      check("rst_cs",    32'(imem_cs),  32'd0);
      check("rst_pc",    if_pc,         32'h0);
      check("rst_inst",  if_inst,       32'h0);

      // Test 1 / 5: stream from reset
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("c0_cs",    32'(imem_cs),   32'd1);
      check("c0_addr",  32'(imem_addr), 32'h0);
      check("c0_addr5", 32'(addr5),     32'h3F8);
      check("c0_valid", 32'(if_valid),  32'd0);
      tick();
      check("c1_addr",  32'(imem_addr), 32'h1);
      check("c1_valid", 32'(if_valid),  32'd0);
      for (int k = 2; k <= 7; k++) begin
         tick();
         check("s_valid", 32'(if_valid), 32'd1);
         check("s_pc",    if_pc,         32'(4 * (k - 2)));
         check("s_inst",  if_inst,       32'h1000_0000 + 32'(k - 2));
         if (k <= 5) check("wrap_pc", pc5, 32'hFFFF_FFF8 + 32'(4 * (k - 2)));
      end

      // Test 2: back-pressure from cycle 8 to 17
      tick();
      if_ready = 1'b0;
      #1;
      check("bp_pc_start", if_pc, 32'd24);
      for (int c = 9; c <= 17; c++) begin
         tick();
         if (c >= 10) begin
            check("bp_cs", 32'(imem_cs), 32'd0);
            check("bp_pc", if_pc,        32'd24);
         end
      end
      tick();
      if_ready = 1'b1;
      for (int j = 0; j <= 5; j++) begin
         if (j > 0) tick();
         check("drain_valid", 32'(if_valid), 32'd1);
         check("drain_pc",    if_pc,         32'(24 + 4 * j));
      end

      // Test 3: redirect at steady stream
      tick();
      br_en   = 1'b1;
      br_addr = 32'h40;
      #1;
      check("br_cs",   32'(imem_cs),   32'd1);
      check("br_addr", 32'(imem_addr), 32'h10);
      check("br_head", if_pc,          32'd48);
      tick();
      br_en = 1'b0;
      #1;
      check("br_bubble", 32'(if_valid), 32'd0);
      for (int j = 0; j < 3; j++) begin
         tick();
         check("br_valid", 32'(if_valid), 32'd1);
         check("br_pc",    if_pc,         32'h40 + 32'(4 * j));
         check("br_inst",  if_inst,       32'h1000_0010 + 32'(j));
      end

      // Test 4: redirect with FIFO full and ID stalled
      tick();
      if_ready = 1'b0;
      for (int c = 0; c < 7; c++) tick();
      check("full_cs", 32'(imem_cs), 32'd0);
      check("full_pc", if_pc,        32'h4C);
      tick();
      br_en   = 1'b1;
      br_addr = 32'h83;
      #1;
      check("brf_cs",   32'(imem_cs),   32'd1);
      check("brf_addr", 32'(imem_addr), 32'h20);
      tick();
      br_en = 1'b0;
      #1;
      check("brf_bubble", 32'(if_valid), 32'd0);
      tick();
      check("brf_valid", 32'(if_valid), 32'd1);
      check("brf_pc",    if_pc,         32'h80);
      check("brf_inst",  if_inst,       32'h1000_0020);

      // Test 6: async reset with 3 entries buffered
      tick();
      tick();
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(if_valid), 32'd0);
      check("arst_cs",    32'(imem_cs),  32'd0);
      check("arst_cs5",   32'(cs5),      32'd0);
      check("arst_pc",    if_pc,         32'h0);
      if_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("re_cs",   32'(imem_cs),   32'd1);
      check("re_addr", 32'(imem_addr), 32'h0);
      tick();
      check("re_c1_valid", 32'(if_valid), 32'd0);
      tick();
      check("re_valid", 32'(if_valid), 32'd1);
      check("re_pc",    if_pc,         32'h0);
      check("re_inst",  if_inst,       32'h1000_0000);
      check("re_pc5",   pc5,           32'hFFFF_FFF8);
      tick();
      check("re_pc_next", if_pc, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
